port_arbiter: RTL and testbench
===============================

# port_arbiter

Sequencer and round-robin arbiter that shares a single GPIO port (direction register plus output register) between NREQ requesters, such as the CPU core and peripheral engines. It accepts one command per request/ack handshake and drives the port's register-enable strobes. It sequences output enable so that data is always loaded before the direction flips to output. It also keeps shadow copies of both port registers for readback.

## Interface
- WIDTH, 8: port data width.
- NREQ, 2: number of requesters (≥2); GW = $clog2(NREQ).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  request per requester; held high until its ack.
- req_op  in  2*NREQ  command per requester, slice i = [2i+1:2i]: 00 WRITE_DATA, 01 SET_DIR, 10 ENABLE, 11 DISABLE.
- req_data  in  WIDTH*NREQ  payload per requester, slice i = [WIDTH*(i+1)-1:WIDTH*i].
- ack  out  NREQ  one-cycle completion pulse, one-hot.
- busy  out  1  high whenever the FSM is not IDLE.
- grant_id  out  GW  index of the current or last granted requester.
- cePortDir  out  1  direction-register write strobe.
- portDir  out  1  direction value (1 = output, 0 = input).
- cePortOut  out  1  output-register write strobe.
- portData  out  WIDTH  output-register value.
- dir_shadow  out  1  last direction written.
- out_shadow  out  WIDTH  last data written.

## Operation
- FSM states: IDLE, EXEC, EXEC2, DONE.
- IDLE
  - Sample req.
  - If any bit is set, select the winner round-robin, searching from (last_grant+1) mod NREQ upward with wrap.
  - Latch the winner's index, op and data into internal registers, then go to EXEC.
  - With no request, stay in IDLE.
- EXEC, from latched op:
  - WRITE_DATA: cePortOut=1, portData=data; then DONE.
  - SET_DIR: cePortDir=1, portDir=data[0]; then DONE.
  - ENABLE: cePortOut=1, portData=data; then EXEC2.
  - DISABLE: cePortDir=1, portDir=0; then DONE. Data is ignored.
- EXEC2 (ENABLE only): cePortDir=1, portDir=1; then DONE.
- DONE: ack[grant]=1; last_grant<=grant; then IDLE.
- Outputs are registered Moore outputs.
  - Strobes are high only in the states listed above, and never both high in the same cycle.
  - portData and portDir are 0 whenever their strobe is low.
- Shadows update on the same edge on which the corresponding strobe is presented to the port. The shadow equals the port register contents from the next cycle on.
- Requests are sampled only in IDLE.
  - req_op and req_data must stay stable from req rise until ack.
  - A requester must sample ack at the clock edge and drop req at that same edge, so req is already low in the following IDLE cycle.
- Changes to req during EXEC, EXEC2 or DONE are ignored. The latched command completes unchanged.
- Reset (any state, including mid-command):
  - State = IDLE, last_grant = NREQ-1 (requester 0 wins first), grant_id = 0.
  - ack, busy, strobes, portDir, portData, dir_shadow and out_shadow are all 0.
  - The interrupted command is dropped with no ack.

## Timing
- Single-step op (WRITE_DATA, SET_DIR, DISABLE), with req sampled in cycle 0:
  - Strobe in cycle 1.
  - ack in cycle 2.
  - IDLE in cycle 3.
- ENABLE:
  - cePortOut in cycle 1.
  - cePortDir in cycle 2.
  - ack in cycle 3.
  - Data is loaded one cycle before the direction flips, so no stale data is driven.
- busy is high from cycle 1 through the ack cycle.
- Throughput: at most one command per 3 cycles (4 for ENABLE).
- Starvation bound: a held request is acked within NREQ commands.

## Test plan
- Reset, then requester 0 issues WRITE_DATA 0xA5:
  - cePortOut=1 with portData=0xA5 exactly one cycle after sampling.
  - ack=2'b01 the following cycle.
  - out_shadow=0xA5 afterwards.
- Requester 1 issues ENABLE 0x3C:
  - cycle 1: cePortOut=1, portData=0x3C.
  - cycle 2: cePortDir=1, portDir=1.
  - cycle 3: ack=2'b10.
  - dir_shadow=1; the two strobes never overlap.
- Both requesters request continuously (NREQ=2), each re-raising req after its ack:
  - Grants alternate 0,1,0,1 starting with 0 after reset.
  - No ack is ever two-hot.
- Reset asserted in EXEC2 of an ENABLE:
  - Next cycle: IDLE, no ack, all strobes 0.
  - dir_shadow=0 and out_shadow=0.
  - The next request from requester 0 wins.
- SET_DIR with data=0xFF, then DISABLE with data=0xFF:
  - First command: portDir=1.
  - Second command: portDir=0 on cePortDir.
  - dir_shadow goes 1 then 0.
  - out_shadow is unchanged.
- req_op and req_data change during EXEC:
  - The original latched values appear on the port.
  - Single ack.

Source files
------------

// File: rtl/port_arbiter.sv
// Round-robin arbiter and sequencer sharing one GPIO port (direction + output
// registers) between NREQ requesters, with shadow copies for readback.
module port_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2,
  localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic [GW-1:0]         grant_id,
  output logic                  cePortDir,
  output logic                  portDir,
  output logic                  cePortOut,
  output logic [WIDTH-1:0]      portData,
  output logic                  dir_shadow,
  output logic [WIDTH-1:0]      out_shadow
);

  // state | meaning
  // IDLE  | waiting for a request; arbitrates and latches the winner
  // EXEC  | first port access of the latched command
  // EXEC2 | ENABLE only: direction flips to output after data is loaded
  // DONE  | ack pulse to the granted requester, grant history updated
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_EXEC2, S_DONE} state_t;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_DIR = 2'b01;
  localparam logic [1:0] OP_EN  = 2'b10;
  localparam logic [1:0] OP_DIS = 2'b11;

  state_t           state, state_nxt;
  logic [GW-1:0]    last_grant, last_nxt;
  logic [GW-1:0]    grant_nxt;
  logic [1:0]       op_q, op_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic [NREQ-1:0]  ack_nxt;
  logic             busy_nxt;
  logic             ce_dir_nxt, dir_nxt;
  logic             ce_out_nxt;
  logic [WIDTH-1:0] port_nxt;
  logic             found;
  logic [GW-1:0]    win, rr_idx;

  // Outputs are registered from the next-state decode, so they line up with
  // the state they belong to.
  always_comb begin
    state_nxt  = state;
    last_nxt   = last_grant;
    grant_nxt  = grant_id;
    op_nxt     = op_q;
    data_nxt   = data_q;
    ack_nxt    = '0;
    ce_dir_nxt = 1'b0;
    dir_nxt    = 1'b0;
    ce_out_nxt = 1'b0;
    port_nxt   = '0;
    found      = 1'b0;
    win        = '0;
    rr_idx     = '0;

    for (int k = 1; k <= NREQ; k++) begin
      rr_idx = GW'((int'(last_grant) + k) % NREQ);
      if (!found && req[rr_idx]) begin
        found = 1'b1;
        win   = rr_idx;
      end
    end

    case (state)
      S_IDLE: begin
        if (found) begin
          grant_nxt = win;
          op_nxt    = req_op[2*win +: 2];
          data_nxt  = req_data[WIDTH*win +: WIDTH];
          state_nxt = S_EXEC;
          case (op_nxt)
            OP_WR, OP_EN: begin
              ce_out_nxt = 1'b1;
              port_nxt   = data_nxt;
            end
            OP_DIR: begin
              ce_dir_nxt = 1'b1;
              dir_nxt    = data_nxt[0];
            end
            OP_DIS: ce_dir_nxt = 1'b1;
            default: ;
          endcase
        end
      end
      S_EXEC: begin
        if (op_q == OP_EN) begin
          state_nxt  = S_EXEC2;
          ce_dir_nxt = 1'b1;
          dir_nxt    = 1'b1;
        end else begin
          state_nxt         = S_DONE;
          ack_nxt[grant_id] = 1'b1;
        end
      end
      S_EXEC2: begin
        state_nxt         = S_DONE;
        ack_nxt[grant_id] = 1'b1;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        last_nxt  = grant_id;
      end
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= GW'(NREQ - 1);
      grant_id   <= '0;
      op_q       <= OP_WR;
      data_q     <= '0;
      ack        <= '0;
      busy       <= 1'b0;
      cePortDir  <= 1'b0;
      portDir    <= 1'b0;
      cePortOut  <= 1'b0;
      portData   <= '0;
      dir_shadow <= 1'b0;
      out_shadow <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_nxt;
      grant_id   <= grant_nxt;
      op_q       <= op_nxt;
      data_q     <= data_nxt;
      ack        <= ack_nxt;
      busy       <= busy_nxt;
      cePortDir  <= ce_dir_nxt;
      portDir    <= dir_nxt;
      cePortOut  <= ce_out_nxt;
      portData   <= port_nxt;
      // Shadows track the value being strobed, one cycle ahead of the port
      if (ce_dir_nxt) dir_shadow <= dir_nxt;
      if (ce_out_nxt) out_shadow <= port_nxt;
    end
  end

endmodule

// File: tb/tb_port_arbiter.sv
// Directed bench for port_arbiter (WIDTH=8, NREQ=2): handshake timing,
// ENABLE sequencing, round-robin fairness, reset abort and latching.
module tb_port_arbiter;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_DIR = 2'b01;
  localparam logic [1:0] OP_EN  = 2'b10;
  localparam logic [1:0] OP_DIS = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [3:0]  req_op;
  logic [15:0] req_data;
  logic [1:0]  ack;
  logic        busy;
  logic [0:0]  grant_id;
  logic        cePortDir, portDir, cePortOut;
  logic [7:0]  portData;
  logic        dir_shadow;
  logic [7:0]  out_shadow;

  int n_cmp = 0;
  int n_err = 0;

  port_arbiter #(.WIDTH(8), .NREQ(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_data(req_data),
    .ack(ack), .busy(busy), .grant_id(grant_id),
    .cePortDir(cePortDir), .portDir(portDir), .cePortOut(cePortOut),
    .portData(portData), .dir_shadow(dir_shadow), .out_shadow(out_shadow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Runs one command to completion without cycle-level checks
  task automatic run_cmd(input int i, input logic [1:0] op, input logic [7:0] d);
    bit got_ack = 0;
    req_op[2*i +: 2]   = op;
    req_data[8*i +: 8] = d;
    req[i] = 1'b1;
    for (int c = 0; c < 12 && !got_ack; c++) begin
      step();
      if (ack[i]) got_ack = 1;
    end
    req[i] = 1'b0;
    check_val("run_cmd_ack", 32'(got_ack), 32'd1);
    step();
  endtask

  initial begin
    int order[$];
    logic [1:0] pend;
    int n_ack;

    req_op = '0;
    req_data = '0;
    do_reset();

    // reset state
    check_val("rst_ack", ack, 2'b00);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_grant", grant_id, 1'b0);
    check_val("rst_ce", {cePortDir, cePortOut}, 2'b00);
    check_val("rst_port", {portDir, portData}, 9'h0);
    check_val("rst_shadow", {dir_shadow, out_shadow}, 9'h0);

    // requester 0 WRITE_DATA 0xA5
    req_op[1:0] = OP_WR; req_data[7:0] = 8'hA5; req = 2'b01;
    step();
    check_val("wr_ceout", cePortOut, 1'b1);
    check_val("wr_data", portData, 8'hA5);
    check_val("wr_cedir", cePortDir, 1'b0);
    check_val("wr_busy", busy, 1'b1);
    step();
    check_val("wr_ack", ack, 2'b01);
    check_val("wr_ceout_off", {cePortOut, portData}, 9'h0);
    check_val("wr_busy_ack", busy, 1'b1);
    req = 2'b00;
    step();
    check_val("wr_idle_busy", busy, 1'b0);
    check_val("wr_idle_ack", ack, 2'b00);
    check_val("wr_oshadow", out_shadow, 8'hA5);

    // requester 1 ENABLE 0x3C
    req_op[3:2] = OP_EN; req_data[15:8] = 8'h3C; req = 2'b10;
    step();
    check_val("en_c1_ceout", {cePortOut, portData}, {1'b1, 8'h3C});
    check_val("en_c1_cedir", cePortDir, 1'b0);
    check_val("en_c1_grant", grant_id, 1'b1);
    step();
    check_val("en_c2_cedir", {cePortDir, portDir}, 2'b11);
    check_val("en_c2_ceout", cePortOut, 1'b0);
    check_val("en_c2_ack", ack, 2'b00);
    step();
    check_val("en_c3_ack", ack, 2'b10);
    check_val("en_c3_ce", {cePortDir, cePortOut}, 2'b00);
    check_val("en_dshadow", dir_shadow, 1'b1);
    req = 2'b00;
    step();
    check_val("en_idle_busy", busy, 1'b0);

    // continuous requests from both: grants alternate starting with 0
    do_reset();
    req_op = {OP_WR, OP_WR}; req_data = 16'h2211; req = 2'b11; pend = 2'b00;
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      step();
      check_val("rr_onehot", 32'($countones(ack) <= 1), 32'd1);
      req = req | pend;
      pend = 2'b00;
      if (ack != 2'b00) begin
        int idx;
        idx = ack[1] ? 1 : 0;
        order.push_back(idx);
        req[idx] = 1'b0;
        pend[idx] = 1'b1;
      end
    end
    req = 2'b00;
    for (int i = 0; i < 4; i++)
      check_val($sformatf("rr_order%0d", i), (order.size() > i) ? order[i] : 99, i % 2);
    step();
    step();

    // make requester 0 the last grant, then abort an ENABLE of requester 1
    run_cmd(0, OP_WR, 8'h44);
    req_op[3:2] = OP_EN; req_data[15:8] = 8'h5A; req = 2'b10;
    step();
    check_val("ab_ceout", {cePortOut, portData}, {1'b1, 8'h5A});
    step();
    check_val("ab_exec2", {cePortDir, portDir}, 2'b11);
    rst = 1'b1; req = 2'b00;
    step();
    rst = 1'b0;
    check_val("ab_ack", ack, 2'b00);
    check_val("ab_busy", busy, 1'b0);
    check_val("ab_ce", {cePortDir, cePortOut}, 2'b00);
    check_val("ab_shadow", {dir_shadow, out_shadow}, 9'h0);
    check_val("ab_grant", grant_id, 1'b0);
    req_op = {OP_WR, OP_WR}; req_data = 16'h2211; req = 2'b11;
    step();
    check_val("ab_first_grant", grant_id, 1'b0);
    check_val("ab_first_data", portData, 8'h11);
    step();
    check_val("ab_first_ack", ack, 2'b01);
    req = 2'b10;
    step();
    step();
    check_val("ab_second_grant", grant_id, 1'b1);
    check_val("ab_second_data", portData, 8'h22);
    step();
    check_val("ab_second_ack", ack, 2'b10);
    req = 2'b00;
    step();
    check_val("ab_oshadow", out_shadow, 8'h22);

    // SET_DIR 0xFF then DISABLE 0xFF
    req_op[1:0] = OP_DIR; req_data[7:0] = 8'hFF; req = 2'b01;
    step();
    check_val("sd_dir", {cePortDir, portDir, cePortOut}, 3'b110);
    check_val("sd_dshadow", dir_shadow, 1'b1);
    step();
    check_val("sd_ack", ack, 2'b01);
    req = 2'b00;
    step();
    req_op[1:0] = OP_DIS; req_data[7:0] = 8'hFF; req = 2'b01;
    step();
    check_val("dis_dir", {cePortDir, portDir, cePortOut}, 3'b100);
    check_val("dis_dshadow", dir_shadow, 1'b0);
    check_val("dis_oshadow", out_shadow, 8'h22);
    step();
    check_val("dis_ack", ack, 2'b01);
    req = 2'b00;
    step();

    // command inputs change during EXEC: latched values must win
    req_op[1:0] = OP_WR; req_data[7:0] = 8'h77; req = 2'b01;
    step();
    check_val("lat_data", {cePortOut, portData}, {1'b1, 8'h77});
    req_op[1:0] = OP_EN; req_data[7:0] = 8'h00;
    step();
    check_val("lat_ack", ack, 2'b01);
    check_val("lat_nodir", cePortDir, 1'b0);
    req = 2'b00;
    n_ack = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (ack != 2'b00) n_ack++;
    end
    check_val("lat_single_ack", n_ack, 0);
    check_val("lat_oshadow", out_shadow, 8'h77);
    check_val("lat_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
